// File: rtl/int_stimulus_gen_if.sv
// rtl/int_stimulus_gen_if.sv - CPU-side bus bundle for the interrupt stimulus generator
interface int_stimulus_gen_if #(
    parameter int NCH = 2
);
    logic [31:0]    macroscopic_pc;
    logic [31:0]    m_int_addr;
    logic [3:0]     m_int_byteen;
    logic [NCH-1:0] interrupt;
    logic           int_any;

    modport master (
        output macroscopic_pc,
        output m_int_addr,
        output m_int_byteen,
        input  interrupt,
        input  int_any
    );

    modport slave (
        input  macroscopic_pc,
        input  m_int_addr,
        input  m_int_byteen,
        output interrupt,
        output int_any
    );
endinterface

// File: rtl/int_stimulus_gen.sv
// rtl/int_stimulus_gen.sv - multi-channel PC-triggered interrupt stimulus generator
module int_stimulus_gen #(
    parameter int               NCH        = 2,
    parameter logic [NCH*32-1:0] TARGET_PC = {NCH{32'h0000300c}},
    parameter logic [31:0]      ACK_BASE   = 32'h00007f20,
    parameter int               DELAY      = 0,
    parameter int               MAX_FIRES  = 1,
    parameter logic [NCH-1:0]   PULSE_MASK = '0,
    parameter int               TIMEOUT    = 0
) (
    input  logic                clk,
    input  logic                reset,
    int_stimulus_gen_if.slave   bus,
    output logic [NCH*8-1:0]    fire_count,
    output logic [NCH-1:0]      timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_ASSERT,
        S_LEAVE,
        S_DONE
    } state_t;

    localparam logic [7:0]  DELAY_C   = 8'(DELAY);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [31:0] MAX_C     = 32'(MAX_FIRES);

    logic [NCH-1:0] irq_vec;

    assign bus.interrupt = irq_vec;
    assign bus.int_any   = |irq_vec;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [31:0] TGT      = TARGET_PC[32*c +: 32];
        localparam logic [31:0] ACK_ADDR = ACK_BASE + 32'(4 * c);
        localparam logic        IS_PULSE = PULSE_MASK[c];

        state_t      state, state_nxt;
        logic [7:0]  cnt, cnt_nxt;
        logic [15:0] timer, timer_nxt;
        logic [7:0]  fires, fires_nxt, fires_inc;
        logic        terr, terr_nxt;
        logic        irq;
        logic        match, ack;

        // Word-granular compares: the low two address bits never matter.
        assign match     = (bus.macroscopic_pc & ~32'd3) == TGT;
        assign ack       = (|bus.m_int_byteen) && ((bus.m_int_addr & ~32'd3) == ACK_ADDR);
        assign fires_inc = (fires == 8'hff) ? fires : fires + 8'd1;

        // Channel sequencing: trigger, optional delay, assert, wait for PC to leave.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            timer_nxt = timer;
            fires_nxt = fires;
            terr_nxt  = terr;
            case (state)
                S_IDLE: begin
                    if (match) begin
                        timer_nxt = '0;
                        if (DELAY_C == 8'd0) begin
                            state_nxt = S_ASSERT;
                        end else begin
                            cnt_nxt   = DELAY_C;
                            state_nxt = S_DELAY;
                        end
                    end
                end
                S_DELAY: begin
                    cnt_nxt = cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state_nxt = S_ASSERT;
                    end
                end
                S_ASSERT: begin
                    if (IS_PULSE) begin
                        fires_nxt = fires_inc;
                        state_nxt = S_LEAVE;
                    end else if (ack) begin
                        // An ack in the expiry cycle still counts as a clean fire.
                        fires_nxt = fires_inc;
                        state_nxt = S_LEAVE;
                    end else if (TIMEOUT_C != 16'd0 && timer == TIMEOUT_C - 16'd1) begin
                        terr_nxt  = 1'b1;
                        state_nxt = S_LEAVE;
                    end else begin
                        timer_nxt = timer + 16'd1;
                    end
                end
                S_LEAVE: begin
                    // Holding the PC on the target must not re-trigger the channel.
                    if (!match) begin
                        if (MAX_C != 32'd0 && {24'd0, fires} >= MAX_C) begin
                            state_nxt = S_DONE;
                        end else begin
                            state_nxt = S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    state_nxt = S_DONE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end

        // Channel state, counters and the registered interrupt line.
        always_ff @(posedge clk) begin
            if (reset) begin
                state <= S_IDLE;
                cnt   <= '0;
                timer <= '0;
                fires <= '0;
                terr  <= 1'b0;
                irq   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                timer <= timer_nxt;
                fires <= fires_nxt;
                terr  <= terr_nxt;
                irq   <= (state_nxt == S_ASSERT);
            end
        end

        assign irq_vec[c]          = irq;
        assign fire_count[8*c +: 8] = fires;
        assign timeout_err[c]      = terr;
    end

endmodule

// File: tb/tb_int_stimulus_gen.sv
// tb/tb_int_stimulus_gen.sv - scoreboard bench for int_stimulus_gen
module tb_int_stimulus_gen;

    localparam logic [31:0] TGT  = 32'h0000300c;
    localparam logic [31:0] ACK0 = 32'h00007f20;
    localparam logic [31:0] ACK1 = 32'h00007f24;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [3:0]  ben;
    int          sel;
    int          cyc = 0;
    logic        rst_q = 1'b1;
    logic [1:0]  obs;
    logic [1:0]  prev = 2'b00;
    int          pulse_rises = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    int rq0[$];
    int rq1[$];
    int fq0[$];
    int fq1[$];

    always #5 clk = ~clk;

    int_stimulus_gen_if #(.NCH(1)) if_basic ();
    int_stimulus_gen_if #(.NCH(2)) if_delay ();
    int_stimulus_gen_if #(.NCH(1)) if_rep ();
    int_stimulus_gen_if #(.NCH(2)) if_pulse ();
    int_stimulus_gen_if #(.NCH(1)) if_to ();

    assign if_basic.macroscopic_pc = pc;
    assign if_basic.m_int_addr     = addr;
    assign if_basic.m_int_byteen   = ben;
    assign if_delay.macroscopic_pc = pc;
    assign if_delay.m_int_addr     = addr;
    assign if_delay.m_int_byteen   = ben;
    assign if_rep.macroscopic_pc   = pc;
    assign if_rep.m_int_addr       = addr;
    assign if_rep.m_int_byteen     = ben;
    assign if_pulse.macroscopic_pc = pc;
    assign if_pulse.m_int_addr     = addr;
    assign if_pulse.m_int_byteen   = ben;
    assign if_to.macroscopic_pc    = pc;
    assign if_to.m_int_addr        = addr;
    assign if_to.m_int_byteen      = ben;

    logic [7:0]  fc_basic, fc_rep, fc_to;
    logic [15:0] fc_delay, fc_pulse;
    logic        te_basic, te_rep, te_to;
    logic [1:0]  te_delay, te_pulse;

    int_stimulus_gen #(.NCH(1), .TARGET_PC(TGT)) u_basic (
        .clk(clk), .reset(reset), .bus(if_basic), .fire_count(fc_basic), .timeout_err(te_basic));

    int_stimulus_gen #(.NCH(2), .TARGET_PC({TGT, TGT}), .DELAY(3)) u_delay (
        .clk(clk), .reset(reset), .bus(if_delay), .fire_count(fc_delay), .timeout_err(te_delay));

    int_stimulus_gen #(.NCH(1), .TARGET_PC(TGT), .MAX_FIRES(2)) u_rep (
        .clk(clk), .reset(reset), .bus(if_rep), .fire_count(fc_rep), .timeout_err(te_rep));

    int_stimulus_gen #(.NCH(2), .TARGET_PC({32'h00005000, TGT}), .MAX_FIRES(0),
                       .PULSE_MASK(2'b01)) u_pulse (
        .clk(clk), .reset(reset), .bus(if_pulse), .fire_count(fc_pulse), .timeout_err(te_pulse));

    int_stimulus_gen #(.NCH(1), .TARGET_PC(TGT), .TIMEOUT(10)) u_to (
        .clk(clk), .reset(reset), .bus(if_to), .fire_count(fc_to), .timeout_err(te_to));

    always_comb begin
        obs = 2'b00;
        case (sel)
            0: obs = {1'b0, if_basic.interrupt};
            1: obs = if_delay.interrupt;
            2: obs = {1'b0, if_rep.interrupt};
            3: obs = if_pulse.interrupt;
            4: obs = {1'b0, if_to.interrupt};
            default: obs = 2'b00;
        endcase
    end

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic sb_push(input int c, input bit rise, input int at);
        if (c == 0 && rise)       rq0.push_back(at);
        else if (c == 0)          fq0.push_back(at);
        else if (rise)            rq1.push_back(at);
        else                      fq1.push_back(at);
    endtask

    task automatic sb_pop(input int c, input bit rise);
        int exp_cyc;
        exp_cyc = -1;
        if (c == 0 && rise)  begin if (rq0.size() > 0) exp_cyc = rq0.pop_front(); end
        else if (c == 0)     begin if (fq0.size() > 0) exp_cyc = fq0.pop_front(); end
        else if (rise)       begin if (rq1.size() > 0) exp_cyc = rq1.pop_front(); end
        else                 begin if (fq1.size() > 0) exp_cyc = fq1.pop_front(); end
        check($sformatf("sel%0d_ch%0d_%s_cycle", sel, c, rise ? "rise" : "fall"), cyc, exp_cyc);
    endtask

    task automatic sb_drain(input string tag);
        check({tag, "_pending_events"}, rq0.size() + rq1.size() + fq0.size() + fq1.size(), 0);
        rq0.delete();
        rq1.delete();
        fq0.delete();
        fq1.delete();
    endtask

    // Edge monitor: every interrupt edge of the selected DUT is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst_q) begin
            for (int c = 0; c < 2; c++) begin
                if (obs[c] && !prev[c]) begin
                    sb_pop(c, 1'b1);
                    if (sel == 3 && c == 0) pulse_rises++;
                end
                if (!obs[c] && prev[c]) sb_pop(c, 1'b0);
            end
        end
        prev = obs;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int s);
        reset = 1'b1;
        pc    = '0;
        ben   = '0;
        tick();
        sel   = s;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int k;
        reset = 1'b1;
        pc    = '0;
        addr  = '0;
        ben   = '0;
        sel   = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        check("rst_interrupt", if_basic.interrupt, 0);
        check("rst_int_any", if_basic.int_any, 0);
        check("rst_fire_count", fc_delay, 0);
        check("rst_timeout_err", te_to, 0);

        // Basic level fire, ignored zero-byteen write, retirement.
        do_reset(0);
        pc = TGT;
        sb_push(0, 1'b1, cyc + 1);
        tick();
        repeat (4) tick();
        check("basic_int_any", if_basic.int_any, 1);
        addr = ACK0;
        ben  = 4'h0;
        tick();
        check("basic_zero_byteen_held", if_basic.interrupt, 1);
        ben = 4'hf;
        sb_push(0, 1'b0, cyc + 1);
        tick();
        ben = 4'h0;
        pc  = '0;
        tick();
        tick();
        check("basic_fire_count", fc_basic, 1);
        repeat (3) begin
            pc = TGT;
            tick();
            tick();
            pc = '0;
            tick();
            tick();
        end
        check("basic_done_fire_count", fc_basic, 1);
        check("basic_done_int_any", if_basic.int_any, 0);
        sb_drain("basic");

        // Delay, simultaneous channels, misdirected ack and masked low address bits.
        do_reset(1);
        pc = TGT;
        k  = cyc + 1;
        sb_push(0, 1'b1, k + 3);
        sb_push(1, 1'b1, k + 3);
        tick();
        repeat (6) tick();
        addr = ACK1;
        ben  = 4'hf;
        sb_push(1, 1'b0, cyc + 1);
        tick();
        ben = 4'h0;
        repeat (2) tick();
        check("delay_ch0_held", if_delay.interrupt[0], 1);
        addr = 32'h00007f22;
        ben  = 4'b0100;
        sb_push(0, 1'b0, cyc + 1);
        tick();
        ben = 4'h0;
        pc  = '0;
        tick();
        tick();
        check("delay_fire_count", fc_delay, 16'h0101);

        // Reset from DONE, during DELAY and during ASSERT.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_done_fire_count", fc_delay, 0);
        pc = TGT;
        tick();
        tick();
        reset = 1'b1;
        pc    = '0;
        tick();
        reset = 1'b0;
        check("rst_delay_int", if_delay.interrupt, 0);
        repeat (4) tick();
        check("rst_delay_no_late_fire", if_delay.interrupt, 0);
        pc = TGT;
        k  = cyc + 1;
        sb_push(0, 1'b1, k + 3);
        sb_push(1, 1'b1, k + 3);
        tick();
        repeat (5) tick();
        check("pre_rst_assert_int", if_delay.interrupt, 2'b11);
        reset = 1'b1;
        pc    = '0;
        tick();
        reset = 1'b0;
        check("rst_assert_int", if_delay.interrupt, 0);
        check("rst_assert_timeout_err", te_delay, 0);
        pc = TGT;
        k  = cyc + 1;
        sb_push(0, 1'b1, k + 3);
        sb_push(1, 1'b1, k + 3);
        tick();
        repeat (5) tick();
        pc   = '0;
        addr = ACK0;
        ben  = 4'hf;
        sb_push(0, 1'b0, cyc + 1);
        tick();
        addr = ACK1;
        sb_push(1, 1'b0, cyc + 1);
        tick();
        ben = 4'h0;
        tick();
        check("post_rst_fire_count", fc_delay, 16'h0101);
        sb_drain("delay");

        // Repeat limit with the PC held on the target across the ack.
        do_reset(2);
        for (int v = 0; v < 2; v++) begin
            pc = TGT;
            sb_push(0, 1'b1, cyc + 1);
            tick();
            repeat (3) tick();
            addr = ACK0;
            ben  = 4'hf;
            sb_push(0, 1'b0, cyc + 1);
            tick();
            ben = 4'h0;
            repeat (5) tick();
            check("rep_hold_no_reassert", if_rep.interrupt, 0);
            pc = '0;
            tick();
            tick();
            check("rep_fire_count", fc_rep, v + 1);
        end
        pc = TGT;
        repeat (5) tick();
        pc = '0;
        tick();
        check("rep_third_visit_int", if_rep.interrupt, 0);
        check("rep_final_fire_count", fc_rep, 2);
        sb_drain("repeat");

        // Pulse mode: 300 visits, counter saturates.
        do_reset(3);
        pulse_rises = 0;
        for (int i = 0; i < 300; i++) begin
            pc = TGT;
            sb_push(0, 1'b1, cyc + 1);
            sb_push(0, 1'b0, cyc + 2);
            tick();
            pc = '0;
            tick();
            tick();
        end
        check("pulse_count", pulse_rises, 300);
        check("pulse_fire_count_sat", fc_pulse[7:0], 255);
        check("pulse_ch1_fire_count", fc_pulse[15:8], 0);
        sb_drain("pulse");

        // Timeout without ack, then ack landing in the expiry cycle.
        do_reset(4);
        pc = TGT;
        k  = cyc + 1;
        sb_push(0, 1'b1, k);
        sb_push(0, 1'b0, k + 10);
        tick();
        pc = '0;
        repeat (12) tick();
        check("timeout_err_set", te_to, 1);
        check("timeout_fire_count", fc_to, 0);
        sb_drain("timeout");
        do_reset(4);
        check("timeout_err_cleared", te_to, 0);
        pc = TGT;
        k  = cyc + 1;
        sb_push(0, 1'b1, k);
        sb_push(0, 1'b0, k + 10);
        tick();
        pc = '0;
        repeat (9) tick();
        addr = ACK0;
        ben  = 4'hf;
        tick();
        ben = 4'h0;
        repeat (3) tick();
        check("ack_wins_timeout_err", te_to, 0);
        check("ack_wins_fire_count", fc_to, 1);
        sb_drain("ack_vs_timeout");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
